// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared types and constants for the instruction fetch stage:
//               PC mux select encodings, fetch FSM state type, word size.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    // PC mux select encodings produced by the decoder
    localparam logic [1:0] PC_SEL_JR  = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;
    localparam logic [1:0] PC_SEL_SEQ = 2'b11;

    // Bytes per instruction word; sequential PC step
    localparam int unsigned INSTR_BYTES = 4;

    // Fetch FSM states (single outstanding memory request)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Instruction-memory request channel and decoder handshake
//               channel of the fetch stage. master = fetch stage view,
//               slave = memory/decoder view.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pc_target_calc
// Description : Combinational redirect decision and target computation from
//               the decoder's PC mux select and the branch condition.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_pc_target_calc
    import instr_fetch_pkg::*;
(
    input  logic [1:0]  sel,
    input  logic        br_taken,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic [31:0] redir_instr,
    input  logic [31:0] rs_value,
    output logic        redir,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] w_seq;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;
    logic        w_unused_opcode;

    // Sequential address wraps at 32 bits; all targets are word aligned
    assign w_seq       = redir_pc + 32'(INSTR_BYTES);
    assign w_br_off    = {{14{redir_instr[15]}}, redir_instr[15:0], 2'b00};
    assign w_br_target = w_seq + w_br_off;
    assign w_j_target  = {w_seq[31:28], redir_instr[25:0], 2'b00};
    assign w_jr_target = {rs_value[31:2], 2'b00};

    // Opcode bits are decoded upstream; only the immediate fields matter here
    assign w_unused_opcode = ^redir_instr[31:26];

    // Redirect decision, target select and register-jump alignment flag
    always_comb begin
        redir    = redir_valid && (sel != PC_SEL_SEQ) && ((sel != PC_SEL_BR) || br_taken);
        target   = w_jr_target;
        misalign = 1'b0;
        case (sel)
            PC_SEL_BR: target = w_br_target;
            PC_SEL_J:  target = w_j_target;
            default:   target = w_jr_target;
        endcase
        if (redir && (sel == PC_SEL_JR) && (rs_value[1:0] != 2'b00)) begin
            misalign = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage. Holds the PC, issues one outstanding request to
//               instruction memory, latches the returned word and hands it to
//               the decoder with valid/ready. Applies decoder redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_fetch_if.master bus,
    input  logic        redir_valid,
    input  logic [1:0]  pc_mux_sel,
    input  logic        br_taken,
    input  logic [31:0] redir_pc,
    input  logic [31:0] redir_instr,
    input  logic [31:0] rs_value,
    output logic        misalign_err
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_kill;
    logic         w_kill_nxt;
    logic         r_id_valid;
    logic         w_id_valid_nxt;
    logic [31:0]  r_id_instr;
    logic [31:0]  w_id_instr_nxt;
    logic [31:0]  r_id_pc;
    logic [31:0]  w_id_pc_nxt;
    logic         r_imem_req;
    logic [31:0]  r_imem_addr;
    logic         r_misalign;

    logic         w_redir;
    logic [31:0]  w_target;
    logic         w_misalign;

    instr_fetch_pc_target_calc u_target (
        .sel         (pc_mux_sel),
        .br_taken    (br_taken),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .redir_instr (redir_instr),
        .rs_value    (rs_value),
        .redir       (w_redir),
        .target      (w_target),
        .misalign    (w_misalign)
    );

    // State, PC, kill flag, decoder register and registered memory request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_id_valid  <= 1'b0;
            r_id_instr  <= 32'd0;
            r_id_pc     <= 32'd0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_misalign  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_kill      <= w_kill_nxt;
            r_id_valid  <= w_id_valid_nxt;
            r_id_instr  <= w_id_instr_nxt;
            r_id_pc     <= w_id_pc_nxt;
            // Request is driven from the next state so it is high exactly in S_REQ
            r_imem_req  <= (w_state_nxt == S_REQ);
            r_imem_addr <= w_pc_nxt;
            r_misalign  <= w_misalign;
        end
    end

    // Next-state logic; a redirect in any state overrides the PC
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = w_redir ? w_target : r_pc;
        w_kill_nxt     = r_kill;
        w_id_valid_nxt = r_id_valid;
        w_id_instr_nxt = r_id_instr;
        w_id_pc_nxt    = r_id_pc;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_gnt) begin
                    w_state_nxt = S_WAIT;
                    // Granted word belongs to the old path; drop it on return
                    if (w_redir) begin
                        w_kill_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (r_kill || w_redir) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_id_instr_nxt = bus.imem_rdata;
                        w_id_pc_nxt    = r_pc;
                        w_id_valid_nxt = 1'b1;
                        w_state_nxt    = S_FULL;
                    end
                end else if (w_redir) begin
                    w_kill_nxt = 1'b1;
                end
            end
            S_FULL: begin
                // Redirect wins over a simultaneous consume; PC is not stepped
                if (w_redir) begin
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end else if (bus.id_ready) begin
                    w_pc_nxt       = r_pc + 32'(INSTR_BYTES);
                    w_id_valid_nxt = 1'b0;
                    w_state_nxt    = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.id_valid  = r_id_valid;
    assign bus.id_instr  = r_id_instr;
    assign bus.id_pc     = r_id_pc;
    assign misalign_err  = r_misalign;

endmodule
`default_nettype wire
